// File: rtl/cdb_writeback_arbiter.sv
// Common-data-bus writeback arbiter: per-unit result FIFOs feeding one registered
// broadcast lane, with round-robin grant across ALU/MUL/BR/MEM and flush support.
module cdb_writeback_arbiter #(
    parameter int ROB_IDX_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int QDEPTH        = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [3:0]                          src_valid,
    output logic [3:0]                          src_ready,
    input  logic [3:0][ROB_IDX_WIDTH-1:0]       src_rob_idx,
    input  logic [3:0][4:0]                     src_rd_addr,
    input  logic [3:0][DATA_WIDTH-1:0]          src_data,
    output logic                                cdb_valid,
    output logic [1:0]                          cdb_src,
    output logic [ROB_IDX_WIDTH-1:0]            cdb_rob_idx,
    output logic [4:0]                          cdb_rd_addr,
    output logic [DATA_WIDTH-1:0]               cdb_data
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic [ROB_IDX_WIDTH-1:0] q_rob  [4][QDEPTH];
    logic [4:0]               q_rd   [4][QDEPTH];
    logic [DATA_WIDTH-1:0]    q_data [4][QDEPTH];

    logic [PW-1:0] wr_ptr [4];
    logic [PW-1:0] rd_ptr [4];
    logic [CW-1:0] count  [4];
    logic [1:0]    rr_ptr;

    logic [3:0]               push;
    logic [3:0]               pop;
    logic                     grant_valid;
    logic [1:0]               grant;
    logic [1:0]               scan_idx;
    logic [ROB_IDX_WIDTH-1:0] head_rob;
    logic [4:0]               head_rd;
    logic [DATA_WIDTH-1:0]    head_data;

    // Ready looks only at the registered count, so a full queue refuses an
    // offer even in the cycle it is popped.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            src_ready[i] = (count[i] != CW'(QDEPTH));
            push[i]      = src_valid[i] && src_ready[i];
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        scan_idx    = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            scan_idx = rr_ptr + 2'(k);
            if (!grant_valid && count[scan_idx] != '0) begin
                grant_valid = 1'b1;
                grant       = scan_idx;
            end
        end
        pop       = grant_valid ? (4'b0001 << grant) : 4'b0000;
        head_rob  = q_rob[grant][rd_ptr[grant]];
        head_rd   = q_rd[grant][rd_ptr[grant]];
        head_data = q_data[grant][rd_ptr[grant]];
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (push[i]) begin
                q_rob[i][wr_ptr[i]]  <= src_rob_idx[i];
                q_rd[i][wr_ptr[i]]   <= src_rd_addr[i];
                q_data[i][wr_ptr[i]] <= src_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                count[i]  <= '0;
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            rr_ptr      <= '0;
            cdb_valid   <= 1'b0;
            cdb_src     <= '0;
            cdb_rob_idx <= '0;
            cdb_rd_addr <= '0;
            cdb_data    <= '0;
        end else if (flush) begin
            // rr_ptr and the broadcast data fields deliberately survive a flush.
            for (int unsigned i = 0; i < 4; i++) begin
                count[i]  <= '0;
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            cdb_valid <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
            if (grant_valid) begin
                rr_ptr      <= grant + 2'd1;
                cdb_valid   <= 1'b1;
                cdb_src     <= grant;
                cdb_rob_idx <= head_rob;
                cdb_rd_addr <= head_rd;
                cdb_data    <= head_data;
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Bench for cdb_writeback_arbiter: directed vector table, hand-written corner
// sequences, and a randomized run against a queue-based reference model.
module tb_cdb_writeback_arbiter;

    localparam int QD = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [3:0]       src_valid;
    logic [3:0]       src_ready;
    logic [3:0][4:0]  src_rob_idx;
    logic [3:0][4:0]  src_rd_addr;
    logic [3:0][31:0] src_data;
    logic             cdb_valid;
    logic [1:0]       cdb_src;
    logic [4:0]       cdb_rob_idx;
    logic [4:0]       cdb_rd_addr;
    logic [31:0]      cdb_data;

    cdb_writeback_arbiter #(.ROB_IDX_WIDTH(5), .DATA_WIDTH(32), .QDEPTH(QD)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_rob_idx(src_rob_idx), .src_rd_addr(src_rd_addr), .src_data(src_data),
        .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_rob_idx(cdb_rob_idx),
        .cdb_rd_addr(cdb_rd_addr), .cdb_data(cdb_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one SV queue per unit, rotating priority as an integer.
    typedef struct { logic [4:0] rob; logic [4:0] rd; logic [31:0] data; } ent_t;
    ent_t        mq [4][$];
    int          m_rr;
    logic        m_valid;
    logic [1:0]  m_src;
    logic [4:0]  m_rob;
    logic [4:0]  m_rd;
    logic [31:0] m_data;

    function automatic logic [3:0] model_ready();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (mq[i].size() < QD);
        return r;
    endfunction

    task automatic model_step();
        logic [3:0] rdy;
        bit         found;
        ent_t       e;
        if (rst) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            m_rr = 0; m_valid = 0; m_src = 0; m_rob = 0; m_rd = 0; m_data = 0;
        end else if (flush) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            m_valid = 0;
        end else begin
            rdy = model_ready();
            found = 0;
            for (int k = 0; k < 4; k++) begin
                int s;
                s = (m_rr + k) % 4;
                if (!found && mq[s].size() > 0) begin
                    found = 1;
                    e = mq[s].pop_front();
                    m_src = 2'(s); m_rob = e.rob; m_rd = e.rd; m_data = e.data;
                    m_rr = (s + 1) % 4;
                end
            end
            m_valid = found;
            for (int i = 0; i < 4; i++) begin
                if (src_valid[i] && rdy[i]) begin
                    e.rob = src_rob_idx[i]; e.rd = src_rd_addr[i]; e.data = src_data[i];
                    mq[i].push_back(e);
                end
            end
        end
    endtask

    task automatic cyc(input logic r, input logic f, input logic [3:0] v);
        rst = r; flush = f; src_valid = v;
        @(posedge clk);
        model_step();
        #1;
        chk("model_valid", cdb_valid, m_valid);
        chk("model_ready", src_ready, model_ready());
        chk("model_fields", {cdb_src, cdb_rob_idx, cdb_rd_addr, cdb_data},
            {m_src, m_rob, m_rd, m_data});
    endtask

    typedef struct {
        logic [3:0]       valid;
        logic [3:0][4:0]  rob;
        logic [3:0][4:0]  rd;
        logic [3:0][31:0] data;
        logic             exp_valid;
        logic [1:0]       exp_src;
        logic [4:0]       exp_rob;
        logic [4:0]       exp_rd;
        logic [31:0]      exp_data;
        logic [3:0]       exp_ready;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic [3:0][4:0]  crob;
        logic [3:0][4:0]  crd;
        logic [3:0][31:0] cdat;
        crob = {5'd4, 5'd3, 5'd2, 5'd1};
        crd  = {5'd14, 5'd13, 5'd12, 5'd11};
        cdat = {32'h44, 32'h33, 32'h22, 32'h11};
        // Four-way contention, then a single ALU offer.
        tbl[0] = '{4'hF, crob, crd, cdat, 1'b0, 2'd0, 5'd0, 5'd0, 32'h0,  4'hF};
        tbl[1] = '{4'h0, crob, crd, cdat, 1'b1, 2'd0, 5'd1, 5'd11, 32'h11, 4'hF};
        tbl[2] = '{4'h0, crob, crd, cdat, 1'b1, 2'd1, 5'd2, 5'd12, 32'h22, 4'hF};
        tbl[3] = '{4'h0, crob, crd, cdat, 1'b1, 2'd2, 5'd3, 5'd13, 32'h33, 4'hF};
        tbl[4] = '{4'h0, crob, crd, cdat, 1'b1, 2'd3, 5'd4, 5'd14, 32'h44, 4'hF};
        tbl[5] = '{4'h0, crob, crd, cdat, 1'b0, 2'd0, 5'd0, 5'd0, 32'h0,  4'hF};
        crob[0] = 5'd3; crd[0] = 5'd5; cdat[0] = 32'hDEAD;
        tbl[6] = '{4'h1, crob, crd, cdat, 1'b0, 2'd0, 5'd0, 5'd0, 32'h0,  4'hF};
        tbl[7] = '{4'h0, crob, crd, cdat, 1'b1, 2'd0, 5'd3, 5'd5, 32'hDEAD, 4'hF};
        tbl[8] = '{4'h0, crob, crd, cdat, 1'b0, 2'd0, 5'd0, 5'd0, 32'h0,  4'hF};

        rst = 1'b1; flush = 1'b0; src_valid = '0;
        src_rob_idx = '0; src_rd_addr = '0; src_data = '0;
        for (int i = 0; i < 4; i++) mq[i].delete();
        m_rr = 0; m_valid = 0; m_src = 0; m_rob = 0; m_rd = 0; m_data = 0;

        cyc(1'b1, 1'b0, 4'h0);
        chk("reset_valid", cdb_valid, 1'b0);
        chk("reset_fields", {cdb_src, cdb_rob_idx, cdb_rd_addr, cdb_data}, '0);
        chk("reset_ready", src_ready, 4'hF);

        for (int i = 0; i < 9; i++) begin
            src_rob_idx = tbl[i].rob; src_rd_addr = tbl[i].rd; src_data = tbl[i].data;
            cyc(1'b0, 1'b0, tbl[i].valid);
            chk($sformatf("tbl%0d_valid", i), cdb_valid, tbl[i].exp_valid);
            chk($sformatf("tbl%0d_ready", i), src_ready, tbl[i].exp_ready);
            if (tbl[i].exp_valid)
                chk($sformatf("tbl%0d_fields", i), {cdb_src, cdb_rob_idx, cdb_rd_addr, cdb_data},
                    {tbl[i].exp_src, tbl[i].exp_rob, tbl[i].exp_rd, tbl[i].exp_data});
        end

        // Round robin: ALU and MEM held valid; once both queues hold work the
        // grants must alternate.
        for (int i = 0; i < 4; i++) begin src_rob_idx[i] = 5'(i); src_rd_addr[i] = 5'(i + 1); end
        begin
            logic [1:0] prev;
            int         ngrants;
            ngrants = 0; prev = 2'd0;
            for (int c = 0; c < 10; c++) begin
                src_data[0] = 32'(c); src_data[3] = 32'(100 + c);
                cyc(1'b0, 1'b0, 4'b1001);
                if (cdb_valid) begin
                    if (ngrants > 0) chk("rr_alternate", cdb_src, ~prev & 2'b11 ^ 2'b00 ? (prev == 2'd0 ? 2'd3 : 2'd0) : 2'd0);
                    prev = cdb_src;
                    ngrants++;
                end
            end
            chk("rr_grant_count", 32'(ngrants), 32'd9);
        end
        for (int c = 0; c < 4; c++) cyc(1'b0, 1'b0, 4'h0);

        // Full queue on MUL, started from reset so rotation begins at ALU.
        cyc(1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 4; i++) src_data[i] = 32'h1000 + 32'(i);
        cyc(1'b0, 1'b0, 4'hF);
        src_data[1] = 32'h2001;
        cyc(1'b0, 1'b0, 4'b0010);
        chk("mul_full_ready", src_ready[1], 1'b0);
        src_data[1] = 32'h3001;
        cyc(1'b0, 1'b0, 4'b0010);
        chk("mul_refused_while_full", src_ready[1], 1'b1);
        chk("mul_first_pop", {cdb_valid, cdb_src, cdb_data}, {1'b1, 2'd1, 32'h1001});
        cyc(1'b0, 1'b0, 4'b0010);
        for (int c = 0; c < 6; c++) cyc(1'b0, 1'b0, 4'h0);

        // Flush with queued ALU/BR work and a concurrent MUL offer.
        cyc(1'b0, 1'b0, 4'b0101);
        cyc(1'b0, 1'b0, 4'b0001);
        cyc(1'b0, 1'b1, 4'b0010);
        chk("flush_valid", cdb_valid, 1'b0);
        chk("flush_ready", src_ready, 4'hF);
        for (int c = 0; c < 5; c++) begin
            cyc(1'b0, 1'b0, 4'h0);
            chk("post_flush_idle", cdb_valid, 1'b0);
        end

        // Reset while broadcasting with queues loaded.
        cyc(1'b0, 1'b0, 4'hF);
        cyc(1'b0, 1'b0, 4'hF);
        chk("pre_reset_busy", cdb_valid, 1'b1);
        cyc(1'b1, 1'b0, 4'hF);
        chk("midreset_outputs", {cdb_valid, cdb_src, cdb_rob_idx, cdb_rd_addr, cdb_data}, '0);
        chk("midreset_ready", src_ready, 4'hF);
        src_rob_idx[2] = 5'd9; src_data[2] = 32'hB0B;
        cyc(1'b0, 1'b0, 4'b0100);
        cyc(1'b0, 1'b0, 4'h0);
        chk("post_reset_br", {cdb_valid, cdb_src, cdb_rob_idx, cdb_data}, {1'b1, 2'd2, 5'd9, 32'hB0B});

        // Randomized run against the model.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++) begin
                src_rob_idx[i] = 5'($urandom);
                src_rd_addr[i] = 5'($urandom);
                src_data[i]    = $urandom;
            end
            cyc(($urandom_range(0, 79) == 0), ($urandom_range(0, 39) == 0), 4'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdb_writeback_arbiter.md
# cdb_writeback_arbiter

Collects completed results from the four execute units (ALU, MUL, BR, MEM), buffers them in small per-unit queues, and broadcasts one result per cycle on a single registered common-data-bus lane. This lane feeds the reservation stations, the ROB and the register-file wakeup logic. It is the transmit end of the CDB protocol that reservation stations snoop for operand capture and completion. Round-robin arbitration guarantees that no unit starves, and a flush empties every queue.

## Interface
- ROB_IDX_WIDTH, 5, width of ROB index tags
- DATA_WIDTH, 32, result data width
- QDEPTH, 2, entries per source queue (power of two, ≥2)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  pipeline flush (branch mispredict), synchronous
- src_valid  in  [3:0]  result offered; index 0=ALU, 1=MUL, 2=BR, 3=MEM
- src_ready  out  [3:0]  queue can accept this cycle
- src_rob_idx  in  [3:0][ROB_IDX_WIDTH-1:0]  ROB tag of offered result
- src_rd_addr  in  [3:0][4:0]  architectural destination (0 = none)
- src_data  in  [3:0][DATA_WIDTH-1:0]  result value
- cdb_valid  out  1  broadcast valid (one-cycle pulse per result)
- cdb_src  out  2  index of the unit being broadcast
- cdb_rob_idx  out  ROB_IDX_WIDTH  broadcast tag
- cdb_rd_addr  out  5  broadcast destination
- cdb_data  out  DATA_WIDTH  broadcast value

## Operation
- Each source has a FIFO of QDEPTH entries {rob_idx, rd_addr, data} with a registered count of width $clog2(QDEPTH)+1.
- src_ready[i] = (count[i] != QDEPTH). It depends on the registered count only and does not see a same-cycle pop. A full queue therefore refuses an offer even in the cycle it is being drained.
- Enqueue on src_valid[i] && src_ready[i]. src_valid without ready is ignored; the unit holds its result.
- Arbitration, combinational each cycle:
  - The arbiter scans sources rr_ptr, rr_ptr+1, … mod 4.
  - The first source with a non-empty queue is granted.
  - The granted queue pops its head.
  - rr_ptr <= grant+1 (mod 4).
  - If no queue is non-empty, rr_ptr is unchanged.
- Broadcast registers: on a grant, cdb_valid<=1 and cdb_src/rob_idx/rd_addr/data <= the popped entry. With no grant, cdb_valid<=0 and the data fields hold their last value.
- Push and pop on the same queue in the same cycle leave count unchanged. Pointers wrap mod QDEPTH.
- rd_addr==0 results are still broadcast; the ROB needs completion. Receivers gate register wakeup on rd_addr.
- Flush:
  - All queue counts and pointers go to 0.
  - cdb_valid<=0 on the same edge.
  - Offers accepted in the flush cycle are discarded.
  - rr_ptr is preserved.
- rst clears everything flush clears, and also sets rr_ptr<=0 and all cdb_* fields <=0.

## Timing
- Reset values: cdb_valid=0, cdb_src=0, cdb_rob_idx=0, cdb_rd_addr=0, cdb_data=0, src_ready=4'b1111 (all queues empty).
- Latency: an offer accepted at edge k is eligible for arbitration in the cycle after k. If granted, cdb_valid is high in the cycle after edge k+1. Minimum latency is one cycle of queueing plus a registered output.
- Each cdb_valid pulse lasts exactly one cycle per result. Back-to-back results give back-to-back pulses.
- Throughput: one broadcast per cycle total.
- Fairness: a non-empty queue is granted within at most 4 cycles.
- Queue order is FIFO. Results from one unit are broadcast in acceptance order; there is no ordering guarantee across units.
- Flush has priority over push, pop and the broadcast register update.
- Reset mid-operation takes effect at the next edge regardless of queue state or pending grants.
- Simultaneous flush and rst behave as rst.

## Test plan
- Single offer: after reset, ALU offers rob 3, rd 5, data 0xDEAD at edge 1 → cdb_valid=1, src=0, rob=3, rd=5, data=0xDEAD in the cycle after edge 2, then cdb_valid=0.
- Four-way contention: all four units offer in one cycle (rob 1..4) → broadcasts in order src 0,1,2,3 on four consecutive cycles; rr_ptr returns to 0.
- Round robin: MEM and ALU held continuously valid → grants alternate 0,3,0,3. Neither unit waits more than one extra cycle.
- Full queue: MUL offers 3 results back-to-back while the arbiter favours other units → src_ready[1]=0 after 2 accepts. The third offer is accepted only after a MUL pop plus one cycle. All 3 MUL results are broadcast in order.
- Flush: 2 entries queued in ALU and 1 in BR, flush asserted together with a new MUL offer → cdb_valid=0 next cycle, src_ready=4'b1111, and nothing is broadcast afterwards, including the MUL offer.
- Reset mid-stream: rst asserted while cdb_valid=1 with queues non-empty → the next cycle shows all outputs at their reset values and rr_ptr=0. A subsequent BR offer is the first broadcast, with src=2.
